// File: rtl/axi2sram_slave.sv
// AXI3 slave bridging single-outstanding bursts onto a synchronous 32-bit SRAM.
module axi2sram_slave #(
    parameter int unsigned MEM_AW = 14
) (
    input  logic              clk,
    input  logic              resetn,
    // read address channel
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    // read data channel
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // write address channel
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    // write data channel
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // write response channel
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // SRAM port
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int unsigned BYTE_AW = MEM_AW + 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_RESP  = 3'd2,
        WR_DATA  = 3'd3,
        WR_RESP  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic [7:0]  beat_q;
    logic        oor_q;
    logic        perr_q;
    logic        rd_first_q;
    logic [31:0] rdata_q;

    logic        last_beat;
    logic [31:0] addr_next;

    // sideband fields that this slave deliberately does not interpret
    logic unused_ok;
    assign unused_ok = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                         wid, addr_q[31:BYTE_AW], addr_q[1:0]};

    assign last_beat = (beat_q == len_q);
    // FIXED keeps the address; INCR and WRAP step one word, wrapping modulo 2^32
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + 32'd4;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: writes win arbitration in IDLE; bursts run to len with no early exit
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (awvalid) begin
                    state_next = WR_DATA;
                end else if (arvalid) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: state_next = RD_RESP;
            RD_RESP: begin
                if (rready) begin
                    state_next = last_beat ? IDLE : RD_ISSUE;
                end
            end
            WR_DATA: begin
                if (wvalid && last_beat) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // burst context: capture on address handshake, step on each completed beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q       <= 4'd0;
            addr_q     <= 32'd0;
            len_q      <= 8'd0;
            burst_q    <= 2'd0;
            beat_q     <= 8'd0;
            oor_q      <= 1'b0;
            perr_q     <= 1'b0;
            rd_first_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            rd_first_q <= (state == RD_ISSUE);
            if (state == RD_RESP) begin
                rdata_q <= rdata;
            end
            case (state)
                IDLE: begin
                    if (awvalid) begin
                        id_q    <= awid;
                        addr_q  <= awaddr;
                        len_q   <= awlen;
                        burst_q <= awburst;
                        beat_q  <= 8'd0;
                        oor_q   <= |awaddr[31:BYTE_AW];
                        perr_q  <= 1'b0;
                    end else if (arvalid) begin
                        id_q    <= arid;
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        burst_q <= arburst;
                        beat_q  <= 8'd0;
                        oor_q   <= |araddr[31:BYTE_AW];
                        perr_q  <= 1'b0;
                    end
                end
                RD_RESP: begin
                    if (rready && !last_beat) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= addr_next;
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        if (wlast != last_beat) begin
                            perr_q <= 1'b1;
                        end
                        if (!last_beat) begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from state; first RD_RESP cycle forwards the SRAM word, later cycles replay the held copy
    always_comb begin
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = RESP_OKAY;
        bvalid     = 1'b0;
        bresp      = RESP_OKAY;
        rid        = id_q;
        bid        = id_q;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_wdata = 32'd0;
        sram_addr  = addr_q[BYTE_AW-1:2];
        rdata      = rdata_q;
        if (rd_first_q) begin
            rdata = oor_q ? 32'd0 : sram_rdata;
        end
        case (state)
            IDLE: begin
                awready = resetn;
                arready = resetn & ~awvalid;
            end
            RD_ISSUE: begin
                sram_en = ~oor_q;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                rresp  = oor_q ? RESP_SLVERR : RESP_OKAY;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    sram_en    = 1'b1;
                    sram_we    = oor_q ? 4'b0000 : wstrb;
                    sram_wdata = wdata;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bresp  = (oor_q || perr_q) ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi2sram_slave.sv
// Bench for axi2sram_slave: directed corner cases plus random bursts against a word-array model.
module tb_axi2sram_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata, sram_wdata, sram_rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb, sram_we;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready, sram_en;
    logic [13:0] sram_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sram_aa [int];
    logic [31:0] ref_aa  [int];

    axi2sram_slave #(.MEM_AW(14)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // contents of a word never written
    function automatic logic [31:0] init_val(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // synchronous SRAM, 1-cycle read latency, output held when idle
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= sram_aa.exists(int'(sram_addr)) ? sram_aa[int'(sram_addr)] : init_val(int'(sram_addr));
            end else begin
                sram_aa[int'(sram_addr)] = merge(sram_aa.exists(int'(sram_addr)) ? sram_aa[int'(sram_addr)]
                                                 : init_val(int'(sram_addr)), sram_wdata, sram_we);
            end
        end
    end

    function automatic logic [31:0] ref_rd(input int w);
        return ref_aa.exists(w) ? ref_aa[w] : init_val(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // called #1 after a posedge; returns #1 after the final R handshake edge
    task automatic do_read(input logic [3:0] id, input logic [31:0] base, input int len, input logic [1:0] burst);
        logic        oor;
        logic [31:0] a, expd;
        int          w, t;
        oor = |base[31:16];
        arid = id; araddr = base; arlen = 8'(len); arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        chk("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            a = (burst == 2'b00) ? base : base + 32'(4 * b);
            w = int'(a[15:2]);
            expd = oor ? 32'd0 : ref_rd(w);
            @(negedge clk);
            chk("rd_issue_rvalid", 32'(rvalid), 32'd0);
            chk("rd_issue_en", 32'(sram_en), 32'(!oor));
            chk("rd_issue_we", 32'(sram_we), 32'd0);
            if (!oor) chk("rd_sram_addr", 32'(sram_addr), 32'(w));
            @(negedge clk);
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rdata", rdata, expd);
            chk("rid", 32'(rid), 32'(id));
            chk("rresp", 32'(rresp), oor ? 32'd2 : 32'd0);
            chk("rlast", 32'(rlast), 32'(b == len));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rd_hold_rvalid", 32'(rvalid), 32'd1);
                chk("rd_hold_rdata", rdata, expd);
                chk("rd_hold_en", 32'(sram_en), 32'd0);
            end
            rready = 1'b1;
            @(posedge clk); #1 rready = 1'b0;
        end
    endtask

    // early < 0: wlast on the true final beat; otherwise wlast only on beat 'early'
    task automatic do_write(input logic [3:0] id, input logic [31:0] base, input int len, input logic [1:0] burst,
                            input int strb_fix, input int early, input bit ar_pending);
        logic        oor, perr, lst;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          w, t;
        oor = |base[31:16];
        perr = 1'b0;
        awid = id; awaddr = base; awlen = 8'(len); awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin @(negedge clk); t++; end
        chk("aw_handshake", 32'(awready), 32'd1);
        if (ar_pending) chk("ar_blocked_idle", 32'(arready), 32'd0);
        @(posedge clk); #1 awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            a = (burst == 2'b00) ? base : base + 32'(4 * b);
            w = int'(a[15:2]);
            d = $urandom;
            s = (strb_fix < 0) ? 4'($urandom) : 4'(strb_fix);
            lst = (early < 0) ? (b == len) : (b == early);
            if (lst != (b == len)) perr = 1'b1;
            wdata = d; wstrb = s; wlast = lst; wvalid = 1'b1;
            @(negedge clk);
            chk("wready", 32'(wready), 32'd1);
            chk("wr_en", 32'(sram_en), 32'd1);
            chk("wr_we", 32'(sram_we), oor ? 32'd0 : 32'(s));
            chk("wr_sram_addr", 32'(sram_addr), 32'(w));
            chk("wr_sram_wdata", sram_wdata, d);
            chk("wr_bvalid_early", 32'(bvalid), 32'd0);
            if (ar_pending) chk("ar_blocked_wr", 32'(arready), 32'd0);
            @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
            if (!oor) ref_aa[w] = merge(ref_rd(w), d, s);
            if (b < len && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("wr_gap_en", 32'(sram_en), 32'd0);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bid", 32'(bid), 32'(id));
        chk("bresp", 32'(bresp), (oor || perr) ? 32'd2 : 32'd0);
        chk("b_sram_en", 32'(sram_en), 32'd0);
        if (ar_pending) chk("ar_blocked_b", 32'(arready), 32'd0);
        repeat ($urandom_range(0, 1)) begin
            @(negedge clk);
            chk("b_hold", 32'(bvalid), 32'd1);
        end
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int          len;
        resetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
        arvalid = 1'b0; awvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", 32'({rid, bid}), 32'd0);
        chk("rst_resp", 32'({rresp, bresp, rlast}), 32'd0);
        chk("rst_sram", 32'({sram_en, sram_we}), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // single read, word 4
        do_read(4'd3, 32'h10, 0, 2'b01);
        // INCR write, 4 beats, half-word strobes
        do_write(4'd7, 32'h100, 3, 2'b01, 4'b0011, -1, 1'b0);
        do_read(4'd8, 32'h100, 3, 2'b01);
        // simultaneous AR and AW: write wins, read follows
        arid = 4'd9; araddr = 32'h104; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1;
        do_write(4'd2, 32'h104, 1, 2'b01, -1, -1, 1'b1);
        do_read(4'd9, 32'h104, 1, 2'b01);
        // out-of-range read
        do_read(4'd1, 32'h0001_0000, 0, 2'b01);
        // out-of-range write then re-read of aliased in-range word
        do_write(4'd4, 32'h0001_0020, 1, 2'b01, -1, -1, 1'b0);
        do_read(4'd4, 32'h20, 1, 2'b01);
        // early wlast
        do_write(4'd5, 32'h200, 1, 2'b01, -1, 0, 1'b0);
        do_read(4'd5, 32'h200, 1, 2'b01);
        // FIXED bursts
        do_write(4'd6, 32'h300, 3, 2'b00, -1, -1, 1'b0);
        do_read(4'd6, 32'h300, 2, 2'b00);
        // WRAP handled as INCR; INCR across 2^32
        do_read(4'd10, 32'h3F8, 3, 2'b10);
        do_read(4'd11, 32'hFFFF_FFFC, 2, 2'b01);
        // maximal 256-beat bursts
        do_write(4'd12, 32'h4000, 255, 2'b01, -1, -1, 1'b0);
        do_read(4'd13, 32'h4000, 255, 2'b01);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) base = 32'($urandom_range(0, 63)) << 2;
            else base = {16'h0, 16'($urandom)} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) base[31:16] = 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom), base, len, 2'($urandom_range(0, 2)), -1,
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1, 1'b0);
            else
                do_read(4'($urandom), base, len, 2'($urandom_range(0, 2)));
        end

        // reset in the middle of a stalled read burst
        arid = 4'd5; araddr = 32'h200; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        chk("mid_ar_ready", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rvalid_held", 32'(rvalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_arready", 32'(arready), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_rid_rlast", 32'({rid, rlast, rresp}), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);
        do_read(4'd14, 32'h100, 1, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
